// File: rtl/pdm_audio_tx_if.sv
// PCM sample handshake into the PDM transmitter.
interface pdm_audio_tx_if #(parameter int SAMPLE_W = 16) ();
  logic [SAMPLE_W-1:0] pcm_data;
  logic                pcm_valid;
  logic                pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter for the mono amplifier: 2-entry sample buffer, bit divider, delta-sigma modulator.
// Define PDM_TX_ORDER2_EN to build the second-order modulator instead of the first-order accumulator.
module pdm_audio_tx #(
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 32,
  parameter int OSR      = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  pdm_audio_tx_if.slave pcm,
  output logic          o_anout,
  output logic          o_ampSD,
  output logic          o_bit_tick,
  output logic          o_underrun
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);

  logic [DIV_W-1:0]           r_div_cnt;
  logic [BIT_W-1:0]           r_bit_cnt;
  logic [SAMPLE_W-1:0]        r_mem [2];
  logic                       r_wr_ptr, r_rd_ptr;
  logic [1:0]                 r_count;
  logic signed [SAMPLE_W-1:0] r_cur;
  logic                       r_ready, r_anout, r_ampsd, r_underrun;

  logic       w_tick, w_bound, w_push, w_pop;
  logic [1:0] w_count_nxt;

  assign w_tick  = i_en & (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_bound = w_tick & (r_bit_cnt == BIT_W'(OSR - 1));
  assign w_push  = pcm.pcm_valid & r_ready;
  assign w_pop   = w_bound & (r_count != 2'd0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

`ifdef PDM_TX_ORDER2_EN
  localparam int IW = SAMPLE_W + 4;
  localparam logic signed [IW+1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] SMIN = {3'b111, {(IW-1){1'b0}}};
  localparam logic signed [IW+1:0] FB   = {{(IW+2-SAMPLE_W){1'b0}}, 1'b1, {(SAMPLE_W-1){1'b0}}};

  logic signed [IW-1:0] r_i1, r_i2, w_i1_nxt, w_i2_nxt;
  logic signed [IW+1:0] w_fb, w_s1, w_s2;

  function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] v);
    if (v > SMAX) return SMAX[IW-1:0];
    if (v < SMIN) return SMIN[IW-1:0];
    return v[IW-1:0];
  endfunction

  // Two guard bits hold the unsaturated sums; i2 integrates the pre-update i1.
  always_comb begin
    w_fb     = r_anout ? FB : -FB;
    w_s1     = (IW+2)'(r_i1) + (IW+2)'(r_cur) - w_fb;
    w_s2     = (IW+2)'(r_i2) + (IW+2)'(r_i1) - w_fb;
    w_i1_nxt = sat(w_s1);
    w_i2_nxt = sat(w_s2);
  end
`else
  logic [SAMPLE_W-1:0] r_acc, w_u;
  logic [SAMPLE_W:0]   w_sum;

  // Offset binary: adding 2^(SAMPLE_W-1) is just an MSB flip.
  assign w_u   = r_cur ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_cur     <= '0;
      r_ready   <= 1'b0;
      r_anout   <= 1'b0;
`ifdef PDM_TX_ORDER2_EN
      r_i1      <= '0;
      r_i2      <= '0;
`else
      r_acc     <= '0;
`endif
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_count   <= w_count_nxt;
      r_ready   <= (w_count_nxt < 2'd2);
      if (w_push) begin
        r_mem[r_wr_ptr] <= pcm.pcm_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_cur    <= r_mem[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_tick) begin
        r_bit_cnt <= w_bound ? '0 : r_bit_cnt + 1'b1;
`ifdef PDM_TX_ORDER2_EN
        r_i1    <= w_i1_nxt;
        r_i2    <= w_i2_nxt;
        r_anout <= ~w_i2_nxt[IW-1];
`else
        r_acc   <= w_sum[SAMPLE_W-1:0];
        r_anout <= w_sum[SAMPLE_W];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ampsd    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_ampsd    <= i_en;
      r_underrun <= r_underrun | (w_bound & (r_count == 2'd0));
    end
  end

  assign pcm.pcm_ready = r_ready;
  assign o_anout       = r_anout;
  assign o_ampSD       = r_ampsd;
  assign o_bit_tick    = w_tick;
  assign o_underrun    = r_underrun;
endmodule

// File: tb/tb_pdm_audio_tx.sv
// Directed bench for pdm_audio_tx (first-order build, SAMPLE_W=16, CLK_DIV=32, OSR=64).
module tb_pdm_audio_tx;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, en, anout, ampsd, tick, und;
  int   checks = 0, errors = 0, nb = 0, cyc_n = 0, last_bnd = 0;
  logic [1023:0] bits;

  pdm_audio_tx_if #(.SAMPLE_W(W)) pif ();

  pdm_audio_tx #(.SAMPLE_W(W), .CLK_DIV(32), .OSR(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .pcm(pif.slave),
    .o_anout(anout), .o_ampSD(ampsd), .o_bit_tick(tick), .o_underrun(und)
  );

  always #5 clk = ~clk;

  // One clock; a tick seen before the edge means anout takes a new bit at it.
  task automatic cyc();
    logic t;
    t = tick;
    @(posedge clk); #1;
    cyc_n++;
    if (t) begin
      bits[nb] = anout;
      nb++;
      if (nb % 64 == 0) last_bnd = cyc_n;
    end
  endtask

  task automatic run_to(input int n);
    int b;
    b = 0;
    while (nb < n && b < n * 40 + 100) begin cyc(); b++; end
    checks++;
    if (nb < n) begin errors++; $display("FAIL run_to bits=%0d required=%0d", nb, n); end
  endtask

  task automatic push(input logic [W-1:0] d);
    int b;
    logic r;
    pif.pcm_valid = 1'b1; pif.pcm_data = d;
    b = 0; r = 1'b0;
    while (!r && b < 3000) begin r = pif.pcm_ready; cyc(); b++; end
    pif.pcm_valid = 1'b0;
    checks++;
    if (!r) begin errors++; $display("FAIL push_accept data=%h accepted=0 required=1", d); end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pif.pcm_valid = 1'b0; pif.pcm_data = '0;
    cyc();
    rst = 1'b0; nb = 0; bits = '0;
  endtask

  task automatic start();
    en = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pif.pcm_valid = 1'b1; pif.pcm_data = 16'h1234;
    cyc();
    checks++;
    if ({anout, ampsd, tick, und, pif.pcm_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b required=00000", {anout, ampsd, tick, und, pif.pcm_ready});
    end
    rst = 1'b0; pif.pcm_valid = 1'b0;
    cyc();
    checks++;
    if (pif.pcm_ready !== 1'b1 || ampsd !== 1'b1) begin
      errors++; $display("FAIL reset_release ready=%b ampsd=%b required=1,1", pif.pcm_ready, ampsd);
    end
  endtask

  task automatic test_zero();
    do_reset(); start();
    push(16'h0000);
    run_to(64);
    checks++;
    if (und !== 1'b0) begin errors++; $display("FAIL zero_underrun got=%b required=0", und); end
    run_to(128);
    checks++;
    if (bits[0 +: 64] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      errors++; $display("FAIL zero_frame0 got=%h required=aaaaaaaaaaaaaaaa", bits[0 +: 64]);
    end
    checks++;
    if (bits[64 +: 64] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      errors++; $display("FAIL zero_frame1 got=%h required=aaaaaaaaaaaaaaaa", bits[64 +: 64]);
    end
  endtask

  task automatic test_extremes();
    do_reset(); start();
    push(16'h8000);
    push(16'h7FFF);
    checks++;
    if (pif.pcm_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b required=0", pif.pcm_ready); end
    run_to(128);
    checks++;
    if (und !== 1'b0) begin errors++; $display("FAIL ext_underrun got=%b required=0", und); end
    run_to(192);
    checks++;
    if (bits[64 +: 64] !== 64'h0) begin
      errors++; $display("FAIL min_frame got=%h required=0000000000000000", bits[64 +: 64]);
    end
    checks++;
    if (bits[128 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL max_frame got=%h required=fffffffffffffffe", bits[128 +: 64]);
    end
  endtask

  task automatic test_back_to_back();
    int  b, acc_cyc;
    logic r, early;
    do_reset(); start();
    push(16'h8000);
    push(16'h0000);
    checks++;
    if (pif.pcm_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b required=0", pif.pcm_ready); end
    pif.pcm_valid = 1'b1; pif.pcm_data = 16'h8000;
    b = 0; r = 1'b0; early = 1'b0; acc_cyc = 0;
    while (!r && b < 5000) begin
      r = pif.pcm_ready;
      if (r && nb < 64) early = 1'b1;
      cyc(); b++;
    end
    acc_cyc = cyc_n;
    pif.pcm_valid = 1'b0;
    checks++;
    if (early || !r) begin errors++; $display("FAIL b2b_third_accept early=%b accepted=%b required=0,1", early, r); end
    checks++;
    if (acc_cyc !== last_bnd + 1) begin
      errors++; $display("FAIL b2b_accept_cycle got=%0d required=%0d", acc_cyc, last_bnd + 1);
    end
    run_to(256);
    checks++;
    if (bits[64 +: 64] !== 64'h0 || bits[128 +: 64] !== 64'hAAAA_AAAA_AAAA_AAAA || bits[192 +: 64] !== 64'h0) begin
      errors++; $display("FAIL b2b_order got=%h_%h_%h required=0000000000000000_aaaaaaaaaaaaaaaa_0000000000000000",
                         bits[64 +: 64], bits[128 +: 64], bits[192 +: 64]);
    end
  endtask

  task automatic test_underrun();
    do_reset(); start();
    push(16'h4000);
    run_to(128);
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b required=1", und); end
    run_to(192);
    checks++;
    if (bits[64 +: 64] !== 64'hEEEE_EEEE_EEEE_EEEE || bits[128 +: 64] !== 64'hEEEE_EEEE_EEEE_EEEE) begin
      errors++; $display("FAIL underrun_hold got=%h_%h required=eeeeeeeeeeeeeeee_eeeeeeeeeeeeeeee",
                         bits[64 +: 64], bits[128 +: 64]);
    end
    en = 1'b0;
    repeat (5) cyc();
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b required=1", und); end
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if (und !== 1'b0) begin errors++; $display("FAIL underrun_clear got=%b required=0", und); end
  endtask

  task automatic test_reset_midframe();
    do_reset(); start();
    push(16'h4000);
    push(16'h8000);
    run_to(84);
    rst = 1'b1; cyc(); rst = 1'b0;
    nb = 0; bits = '0;
    checks++;
    if ({anout, ampsd, pif.pcm_ready, und} !== 4'b0) begin
      errors++; $display("FAIL midreset_outputs got=%b required=0000", {anout, ampsd, pif.pcm_ready, und});
    end
    run_to(64);
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL midreset_flush und=%b required=1", und); end
    run_to(128);
    checks++;
    if (bits[0 +: 64] !== 64'hAAAA_AAAA_AAAA_AAAA || bits[64 +: 64] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      errors++; $display("FAIL midreset_no_replay got=%h_%h required=aaaaaaaaaaaaaaaa_aaaaaaaaaaaaaaaa",
                         bits[0 +: 64], bits[64 +: 64]);
    end
  endtask

  task automatic test_enable();
    int  k, n0;
    logic bad;
    do_reset(); start();
    run_to(3);
    en = 1'b0; #1;
    checks++;
    if (ampsd !== 1'b1) begin errors++; $display("FAIL en_delay_pre got=%b required=1", ampsd); end
    cyc();
    checks++;
    if (ampsd !== 1'b0 || anout !== 1'b0) begin
      errors++; $display("FAIL en_off ampsd=%b anout=%b required=0,0", ampsd, anout);
    end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (anout !== 1'b0 || tick !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL en_idle activity=%b required=0", bad); end
    en = 1'b1;
    cyc();
    checks++;
    if (ampsd !== 1'b1) begin errors++; $display("FAIL en_on got=%b required=1", ampsd); end
    k = 1;
    while (tick !== 1'b1 && k < 100) begin cyc(); k++; end
    checks++;
    if (k + 1 !== 32) begin errors++; $display("FAIL en_first_tick edge=%0d required=32", k + 1); end
    n0 = nb;
    run_to(n0 + 2);
    checks++;
    if ({bits[n0+1], bits[n0]} !== 2'b10) begin
      errors++; $display("FAIL en_acc_cleared got=%b required=10", {bits[n0+1], bits[n0]});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pif.pcm_valid = 1'b0; pif.pcm_data = '0; bits = '0;
    test_reset();
    test_zero();
    test_extremes();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
